axi_lite_bus_bridge: RTL and testbench

AXI_LITE_BUS_BRIDGE -- requirements
Module: axi_lite_bus_bridge

---
 rtl/axi_lite_bus_bridge.sv | 249 ++++++++++++++++++++++++
 tb/tb_axi_lite_bus_bridge.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_bus_bridge.sv
// AXI-Lite responder that turns every write or read transaction into exactly
// one strobed access on a simple native bus, one access outstanding at a time.
// Write address, write data and read address are captured into hold registers
// so that a read and a write arriving together can be served one after another.
module axi_lite_bus_bridge #(
  parameter int ADDRESS    = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [ADDRESS-1:0]      AWADDR,
  input  logic                    WVALID,
  output logic                    WREADY,
  input  logic [DATA_WIDTH-1:0]   WDATA,
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
  output logic                    BVALID,
  input  logic                    BREADY,
  output logic [1:0]              BRESP,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  input  logic [ADDRESS-1:0]      ARADDR,
  output logic                    RVALID,
  input  logic                    RREADY,
  output logic [DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]              RRESP,
  output logic [ADDRESS-1:0]      U_ADDR,
  output logic [DATA_WIDTH-1:0]   U_WDATA,
  output logic [DATA_WIDTH/8-1:0] U_WSTRB,
  output logic                    U_WE,
  output logic                    U_RE,
  input  logic [DATA_WIDTH-1:0]   U_RDATA,
  input  logic                    U_ACK,
  input  logic                    U_ERR
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int CNT_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ACC  = 3'd1,
    WR_RESP = 3'd2,
    RD_ACC  = 3'd3,
    RD_RESP = 3'd4
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic                    r_live;
  logic                    r_awHeld;
  logic                    r_wHeld;
  logic                    r_arHeld;
  logic                    r_lastWasRead;
  logic [ADDRESS-1:0]      r_awAddr;
  logic [ADDRESS-1:0]      r_arAddr;
  logic [ADDRESS-1:0]      r_uAddr;
  logic [DATA_WIDTH-1:0]   r_wData;
  logic [DATA_WIDTH-1:0]   r_uWdata;
  logic [DATA_WIDTH-1:0]   r_rData;
  logic [STRB_W-1:0]       r_wStrb;
  logic [STRB_W-1:0]       r_uWstrb;
  logic                    r_uWe;
  logic                    r_uRe;
  logic [1:0]              r_bResp;
  logic [1:0]              r_rResp;
  logic [CNT_W-1:0]        r_waitCnt;

  logic                    w_idle;
  logic                    w_awHs;
  logic                    w_wHs;
  logic                    w_arHs;
  logic                    w_bHs;
  logic                    w_wrPair;
  logic                    w_rdReq;
  logic                    w_grantWr;
  logic                    w_grantRd;
  logic                    w_inAcc;
  logic                    w_ackSeen;
  logic                    w_timeout;
  logic                    w_accDone;
  logic [1:0]              w_accResp;
  logic [ADDRESS-1:0]      w_wrAddr;
  logic [ADDRESS-1:0]      w_rdAddr;
  logic [DATA_WIDTH-1:0]   w_wrData;
  logic [STRB_W-1:0]       w_wrStrb;

  // r_live keeps all READY outputs low until the first clock after reset release
  assign w_idle  = (r_state == IDLE);
  assign AWREADY = r_live && w_idle && !r_awHeld;
  assign WREADY  = r_live && w_idle && !r_wHeld;
  assign ARREADY = r_live && w_idle && !r_awHeld && !r_wHeld && !r_arHeld;

  assign w_awHs = AWVALID && AWREADY;
  assign w_wHs  = WVALID && WREADY;
  assign w_arHs = ARVALID && ARREADY;
  assign w_bHs  = BVALID && BREADY;

  assign w_wrPair = (r_awHeld || w_awHs) && (r_wHeld || w_wHs);
  assign w_rdReq  = r_arHeld || w_arHs;

  assign w_wrAddr = r_awHeld ? r_awAddr : AWADDR;
  assign w_wrData = r_wHeld ? r_wData : WDATA;
  assign w_wrStrb = r_wHeld ? r_wStrb : WSTRB;
  assign w_rdAddr = r_arHeld ? r_arAddr : ARADDR;

  // The native ack is only honoured once the strobe cycle is over
  assign w_inAcc   = (r_state == WR_ACC) || (r_state == RD_ACC);
  assign w_ackSeen = w_inAcc && !r_uWe && !r_uRe && U_ACK;
  assign w_timeout = w_inAcc && !w_ackSeen && (r_waitCnt == CNT_W'(TIMEOUT - 1));
  assign w_accDone = w_ackSeen || w_timeout;
  assign w_accResp = (w_ackSeen && !U_ERR) ? 2'b00 : 2'b10;

  assign BVALID  = (r_state == WR_RESP);
  assign RVALID  = (r_state == RD_RESP);
  assign BRESP   = r_bResp;
  assign RRESP   = r_rResp;
  assign RDATA   = r_rData;
  assign U_ADDR  = r_uAddr;
  assign U_WDATA = r_uWdata;
  assign U_WSTRB = r_uWstrb;
  assign U_WE    = r_uWe;
  assign U_RE    = r_uRe;

  // State register
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic and read/write arbitration (alternates on a collision)
  always_comb begin
    w_nextState = r_state;
    w_grantWr   = 1'b0;
    w_grantRd   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_wrPair && w_rdReq) begin
          w_grantWr = r_lastWasRead;
          w_grantRd = !r_lastWasRead;
        end else begin
          w_grantWr = w_wrPair;
          w_grantRd = w_rdReq;
        end
        if (w_grantWr) begin
          w_nextState = WR_ACC;
        end else if (w_grantRd) begin
          w_nextState = RD_ACC;
        end
      end
      WR_ACC:  if (w_accDone) w_nextState = WR_RESP;
      WR_RESP: if (BREADY)    w_nextState = IDLE;
      RD_ACC:  if (w_accDone) w_nextState = RD_RESP;
      RD_RESP: if (RREADY)    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Hold registers for the three AXI request channels
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_live   <= 1'b0;
      r_awHeld <= 1'b0;
      r_wHeld  <= 1'b0;
      r_arHeld <= 1'b0;
      r_awAddr <= '0;
      r_wData  <= '0;
      r_wStrb  <= '0;
      r_arAddr <= '0;
    end else begin
      r_live <= 1'b1;
      if (w_bHs) begin
        r_awHeld <= 1'b0;
        r_wHeld  <= 1'b0;
      end else begin
        if (w_awHs) begin
          r_awHeld <= 1'b1;
          r_awAddr <= AWADDR;
        end
        if (w_wHs) begin
          r_wHeld <= 1'b1;
          r_wData <= WDATA;
          r_wStrb <= WSTRB;
        end
      end
      if (w_grantRd) begin
        r_arHeld <= 1'b0;
      end else if (w_arHs) begin
        r_arHeld <= 1'b1;
      end
      if (w_arHs) begin
        r_arAddr <= ARADDR;
      end
    end
  end

  // Native access launch: one-cycle strobes, stable payload, wait counter
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_uWe         <= 1'b0;
      r_uRe         <= 1'b0;
      r_uAddr       <= '0;
      r_uWdata      <= '0;
      r_uWstrb      <= '0;
      r_waitCnt     <= '0;
      r_lastWasRead <= 1'b1;
    end else begin
      r_uWe <= w_grantWr;
      r_uRe <= w_grantRd;
      if (w_grantWr) begin
        r_uAddr       <= w_wrAddr;
        r_uWdata      <= w_wrData;
        r_uWstrb      <= w_wrStrb;
        r_waitCnt     <= '0;
        r_lastWasRead <= 1'b0;
      end else if (w_grantRd) begin
        r_uAddr       <= w_rdAddr;
        r_waitCnt     <= '0;
        r_lastWasRead <= 1'b1;
      end else if (w_inAcc && !w_accDone) begin
        r_waitCnt <= r_waitCnt + CNT_W'(1);
      end
    end
  end

  // Response capture at the end of an access (ack or timeout)
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_bResp <= 2'b00;
      r_rResp <= 2'b00;
      r_rData <= '0;
    end else begin
      if ((r_state == WR_ACC) && w_accDone) begin
        r_bResp <= w_accResp;
      end
      if ((r_state == RD_ACC) && w_accDone) begin
        r_rResp <= w_accResp;
        r_rData <= w_ackSeen ? U_RDATA : '0;
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_bus_bridge.sv
// Directed bench for axi_lite_bus_bridge: reset, arbitration, write/read paths,
// timeout, error response and reset in the middle of an access.
module tb_axi_lite_bus_bridge;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          ACLK    = 1'b0;
  logic          ARESETN = 1'b0;
  logic          AWVALID = 1'b0;
  logic          AWREADY;
  logic [AW-1:0] AWADDR  = '0;
  logic          WVALID  = 1'b0;
  logic          WREADY;
  logic [DW-1:0] WDATA   = '0;
  logic [3:0]    WSTRB   = '0;
  logic          BVALID;
  logic          BREADY  = 1'b0;
  logic [1:0]    BRESP;
  logic          ARVALID = 1'b0;
  logic          ARREADY;
  logic [AW-1:0] ARADDR  = '0;
  logic          RVALID;
  logic          RREADY  = 1'b0;
  logic [DW-1:0] RDATA;
  logic [1:0]    RRESP;
  logic [AW-1:0] U_ADDR;
  logic [DW-1:0] U_WDATA;
  logic [3:0]    U_WSTRB;
  logic          U_WE;
  logic          U_RE;
  logic [DW-1:0] U_RDATA = '0;
  logic          U_ACK   = 1'b0;
  logic          U_ERR   = 1'b0;

  int nCompared   = 0;
  int nMismatched = 0;
  int cyc;

  axi_lite_bus_bridge #(
    .ADDRESS    (AW),
    .DATA_WIDTH (DW),
    .TIMEOUT    (TO)
  ) dut (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .AWVALID (AWVALID),
    .AWREADY (AWREADY),
    .AWADDR  (AWADDR),
    .WVALID  (WVALID),
    .WREADY  (WREADY),
    .WDATA   (WDATA),
    .WSTRB   (WSTRB),
    .BVALID  (BVALID),
    .BREADY  (BREADY),
    .BRESP   (BRESP),
    .ARVALID (ARVALID),
    .ARREADY (ARREADY),
    .ARADDR  (ARADDR),
    .RVALID  (RVALID),
    .RREADY  (RREADY),
    .RDATA   (RDATA),
    .RRESP   (RRESP),
    .U_ADDR  (U_ADDR),
    .U_WDATA (U_WDATA),
    .U_WSTRB (U_WSTRB),
    .U_WE    (U_WE),
    .U_RE    (U_RE),
    .U_RDATA (U_RDATA),
    .U_ACK   (U_ACK),
    .U_ERR   (U_ERR)
  );

  // 100 MHz clock
  always #5 ACLK = ~ACLK;

  // Advance one clock and land 1 ns after the rising edge
  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  // Compare one observed value against its hand-computed expectation
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    nCompared++;
    if (observed !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive the three AXI request channels at once
  task automatic applyStimulus(input logic awv, input logic [AW-1:0] awa,
                               input logic wv, input logic [DW-1:0] wd, input logic [3:0] ws,
                               input logic arv, input logic [AW-1:0] ara);
    AWVALID = awv;
    AWADDR  = awa;
    WVALID  = wv;
    WDATA   = wd;
    WSTRB   = ws;
    ARVALID = arv;
    ARADDR  = ara;
  endtask

  task automatic clearStimulus();
    applyStimulus(1'b0, '0, 1'b0, '0, 4'h0, 1'b0, '0);
  endtask

  // Called in the strobe cycle: wait, pulse U_ACK for one cycle, return with the response visible
  task automatic serviceAck(input int delay, input logic err, input logic [DW-1:0] rdata);
    repeat (delay) tick();
    U_ACK   = 1'b1;
    U_ERR   = err;
    U_RDATA = rdata;
    tick();
    U_ACK   = 1'b0;
    U_ERR   = 1'b0;
  endtask

  function automatic logic pick(input int which);
    case (which)
      0:       return U_WE;
      1:       return U_RE;
      2:       return BVALID;
      default: return RVALID;
    endcase
  endfunction

  // Bounded wait for a DUT output; an expired budget is reported as a failed comparison
  task automatic waitSignal(input string tag, input int which, input int budget, output int cycles);
    cycles = 0;
    while (!pick(which) && cycles < budget) begin
      tick();
      cycles++;
    end
    checkOutput({tag, "_seen"}, 64'(pick(which)), 64'd1);
  endtask

  // Hang guard
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence
  initial begin
    $display("[TB] reset phase");
    ARESETN = 1'b0;
    repeat (3) tick();
    checkOutput("rst_awready", 64'(AWREADY), 64'd0);
    checkOutput("rst_wready",  64'(WREADY),  64'd0);
    checkOutput("rst_arready", 64'(ARREADY), 64'd0);
    checkOutput("rst_bvalid",  64'(BVALID),  64'd0);
    checkOutput("rst_rvalid",  64'(RVALID),  64'd0);
    checkOutput("rst_u_we",    64'(U_WE),    64'd0);
    checkOutput("rst_u_re",    64'(U_RE),    64'd0);
    checkOutput("rst_u_addr",  64'(U_ADDR),  64'd0);
    checkOutput("rst_rdata",   64'(RDATA),   64'd0);
    checkOutput("rst_bresp",   64'(BRESP),   64'd0);
    ARESETN = 1'b1;
    checkOutput("rel_awready_now", 64'(AWREADY), 64'd0);
    tick();
    checkOutput("rel_awready", 64'(AWREADY), 64'd1);
    checkOutput("rel_wready",  64'(WREADY),  64'd1);
    checkOutput("rel_arready", 64'(ARREADY), 64'd1);

    $display("[TB] collision right after reset: write first");
    applyStimulus(1'b1, 32'h100, 1'b1, 32'hA5A5A5A5, 4'hF, 1'b1, 32'h200);
    tick();
    clearStimulus();
    checkOutput("col1_u_we",   64'(U_WE),   64'd1);
    checkOutput("col1_u_re",   64'(U_RE),   64'd0);
    checkOutput("col1_u_addr", 64'(U_ADDR), 64'h100);
    serviceAck(1, 1'b0, '0);
    checkOutput("col1_bvalid", 64'(BVALID), 64'd1);
    BREADY = 1'b1;
    tick();
    BREADY = 1'b0;
    checkOutput("col1_bvalid_done", 64'(BVALID), 64'd0);

    $display("[TB] repeat collision with held read: read first");
    applyStimulus(1'b1, 32'h104, 1'b1, 32'h0BADF00D, 4'hC, 1'b0, '0);
    tick();
    clearStimulus();
    checkOutput("col2_u_re",   64'(U_RE),   64'd1);
    checkOutput("col2_u_we",   64'(U_WE),   64'd0);
    checkOutput("col2_u_addr", 64'(U_ADDR), 64'h200);
    serviceAck(1, 1'b0, 32'h11);
    checkOutput("col2_rvalid", 64'(RVALID), 64'd1);
    checkOutput("col2_rdata",  64'(RDATA),  64'h11);
    RREADY = 1'b1;
    tick();
    RREADY = 1'b0;
    waitSignal("col2_wr", 0, 4, cyc);
    checkOutput("col2_wr_latency", 64'(cyc),     64'd1);
    checkOutput("col2_wr_addr",    64'(U_ADDR),  64'h104);
    checkOutput("col2_wr_data",    64'(U_WDATA), 64'h0BADF00D);
    checkOutput("col2_wr_strb",    64'(U_WSTRB), 64'hC);
    serviceAck(1, 1'b0, '0);
    checkOutput("col2_bvalid", 64'(BVALID), 64'd1);
    BREADY = 1'b1;
    tick();
    BREADY = 1'b0;

    $display("[TB] basic write with minimum latency");
    applyStimulus(1'b1, 32'h10, 1'b1, 32'hDEADBEEF, 4'hF, 1'b0, '0);
    tick();
    clearStimulus();
    checkOutput("wr_u_we",    64'(U_WE),    64'd1);
    checkOutput("wr_u_addr",  64'(U_ADDR),  64'h10);
    checkOutput("wr_u_wdata", 64'(U_WDATA), 64'hDEADBEEF);
    checkOutput("wr_u_wstrb", 64'(U_WSTRB), 64'hF);
    tick();
    checkOutput("wr_u_we_pulse",  64'(U_WE),   64'd0);
    checkOutput("wr_u_addr_hold", 64'(U_ADDR), 64'h10);
    checkOutput("wr_bvalid_early", 64'(BVALID), 64'd0);
    U_ACK = 1'b1;
    tick();
    U_ACK = 1'b0;
    checkOutput("wr_bvalid", 64'(BVALID), 64'd1);
    checkOutput("wr_bresp",  64'(BRESP),  64'd0);
    BREADY = 1'b1;
    tick();
    BREADY = 1'b0;

    $display("[TB] write data ahead of address, slow BREADY");
    applyStimulus(1'b0, '0, 1'b1, 32'hCAFEF00D, 4'h3, 1'b0, '0);
    checkOutput("wfirst_wready_pre", 64'(WREADY), 64'd1);
    tick();
    clearStimulus();
    checkOutput("wfirst_wready_drop", 64'(WREADY), 64'd0);
    checkOutput("wfirst_no_we_1",     64'(U_WE),   64'd0);
    tick();
    checkOutput("wfirst_no_we_2",     64'(U_WE),   64'd0);
    applyStimulus(1'b1, 32'h30, 1'b0, '0, 4'h0, 1'b0, '0);
    tick();
    clearStimulus();
    checkOutput("wfirst_u_we",    64'(U_WE),    64'd1);
    checkOutput("wfirst_u_addr",  64'(U_ADDR),  64'h30);
    checkOutput("wfirst_u_wstrb", 64'(U_WSTRB), 64'h3);
    serviceAck(1, 1'b0, '0);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("wfirst_bvalid_hold%0d", i), 64'(BVALID), 64'd1);
      checkOutput($sformatf("wfirst_bresp_hold%0d", i),  64'(BRESP),  64'd0);
      tick();
    end
    BREADY = 1'b1;
    tick();
    BREADY = 1'b0;
    checkOutput("wfirst_bvalid_done", 64'(BVALID), 64'd0);

    $display("[TB] read with ack after three cycles");
    applyStimulus(1'b0, '0, 1'b0, '0, 4'h0, 1'b1, 32'h24);
    tick();
    clearStimulus();
    checkOutput("rd_u_re",   64'(U_RE),   64'd1);
    checkOutput("rd_u_addr", 64'(U_ADDR), 64'h24);
    serviceAck(3, 1'b0, 32'h12345678);
    checkOutput("rd_rvalid", 64'(RVALID), 64'd1);
    checkOutput("rd_rdata",  64'(RDATA),  64'h12345678);
    checkOutput("rd_rresp",  64'(RRESP),  64'd0);
    tick();
    checkOutput("rd_rvalid_hold", 64'(RVALID), 64'd1);
    checkOutput("rd_rdata_hold",  64'(RDATA),  64'h12345678);
    RREADY = 1'b1;
    tick();
    RREADY = 1'b0;

    $display("[TB] read timeout");
    applyStimulus(1'b0, '0, 1'b0, '0, 4'h0, 1'b1, 32'h40);
    tick();
    clearStimulus();
    checkOutput("to_u_re", 64'(U_RE), 64'd1);
    waitSignal("to_rvalid", 3, 40, cyc);
    checkOutput("to_latency", 64'(cyc),   64'd16);
    checkOutput("to_rresp",   64'(RRESP), 64'd2);
    checkOutput("to_rdata",   64'(RDATA), 64'd0);
    RREADY = 1'b1;
    tick();
    RREADY = 1'b0;

    $display("[TB] write with native error");
    applyStimulus(1'b1, 32'h50, 1'b1, 32'h1, 4'hF, 1'b0, '0);
    tick();
    clearStimulus();
    checkOutput("err_u_we", 64'(U_WE), 64'd1);
    serviceAck(1, 1'b1, '0);
    checkOutput("err_bvalid", 64'(BVALID), 64'd1);
    checkOutput("err_bresp",  64'(BRESP),  64'd2);
    BREADY = 1'b1;
    tick();
    BREADY = 1'b0;

    $display("[TB] reset during read access");
    applyStimulus(1'b0, '0, 1'b0, '0, 4'h0, 1'b1, 32'h60);
    tick();
    clearStimulus();
    checkOutput("mid_u_re", 64'(U_RE), 64'd1);
    tick();
    ARESETN = 1'b0;
    #1;
    checkOutput("mid_rst_u_addr",  64'(U_ADDR),  64'd0);
    checkOutput("mid_rst_u_re",    64'(U_RE),    64'd0);
    checkOutput("mid_rst_rvalid",  64'(RVALID),  64'd0);
    checkOutput("mid_rst_arready", 64'(ARREADY), 64'd0);
    checkOutput("mid_rst_awready", 64'(AWREADY), 64'd0);
    tick();
    ARESETN = 1'b1;
    U_ACK   = 1'b1;
    U_RDATA = 32'hBAD;
    tick();
    checkOutput("late_ack_rvalid1", 64'(RVALID), 64'd0);
    tick();
    checkOutput("late_ack_rvalid2", 64'(RVALID), 64'd0);
    checkOutput("late_ack_arready", 64'(ARREADY), 64'd1);
    U_ACK = 1'b0;
    applyStimulus(1'b0, '0, 1'b0, '0, 4'h0, 1'b1, 32'h64);
    tick();
    clearStimulus();
    checkOutput("post_u_re",   64'(U_RE),   64'd1);
    checkOutput("post_u_addr", 64'(U_ADDR), 64'h64);
    serviceAck(1, 1'b0, 32'h0F0F0F0F);
    checkOutput("post_rvalid", 64'(RVALID), 64'd1);
    checkOutput("post_rdata",  64'(RDATA),  64'h0F0F0F0F);
    checkOutput("post_rresp",  64'(RRESP),  64'd0);
    RREADY = 1'b1;
    tick();
    RREADY = 1'b0;
    checkOutput("post_rvalid_done", 64'(RVALID), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
